dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM port arbiter between the pipeline MEM stage and a host/debug port
//
// The CPU owns the single data RAM port except for one HOST cycle per host
// transaction. A pending host request is granted as soon as the CPU leaves the
// RAM idle, or after MAX_WAIT consecutive contended cycles, whichever is first.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata MEM stage request
//   c_rdata                   RAM read data to MEM stage (pass-through of ram_spo)
//   c_stall                   pipeline freeze while the host owns the RAM
//   h_req/h_we/h_addr/h_wdata host request (level, held until h_ack)
//   h_ack                     one-cycle completion pulse
//   h_rdata                   registered host read data
//   ram_we/ram_a/ram_d        data RAM write enable, address, write data
//   ram_spo                   data RAM asynchronous read data
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_spo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOST = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic          h_ack_q, h_ack_d;
  logic          host_own;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    h_rdata_d  = h_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!h_req) begin
          // Request withdrawn (or never made): forget any accumulated deferral.
          wait_cnt_d = 4'd0;
        end else if (!c_req || wait_cnt_q == WAIT_MAX) begin
          state_d    = S_HOST;
          wait_cnt_d = 4'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_HOST: begin
        // Asynchronous read: for a write this captures the pre-write contents.
        h_rdata_d = ram_spo;
        state_d   = S_ACK;
      end
      S_ACK: begin
        state_d = h_req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!h_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    h_ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      h_rdata_q  <= '0;
      h_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      h_rdata_q  <= h_rdata_d;
      h_ack_q    <= h_ack_d;
    end
  end

  // Port ownership. Reset forces state_q to IDLE asynchronously, so ownership
  // reverts to the CPU immediately; the write enable is additionally gated so
  // no RAM write can land on an edge while rst is high.
  assign host_own = (state_q == S_HOST);
  assign ram_a    = host_own ? h_addr  : c_addr;
  assign ram_d    = host_own ? h_wdata : c_wdata;
  assign ram_we   = !rst && (host_own ? h_we : (c_we && c_req));
  assign c_stall  = host_own && c_req;
  assign c_rdata  = ram_spo;
  assign h_ack    = h_ack_q;
  assign h_rdata  = h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        c_stall;
  logic        h_req, h_we;
  logic [7:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_ack;
  logic [31:0] h_rdata;
  logic        ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_d, ram_spo;

  logic [31:0] mem [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a  = '0;
  logic [31:0] ld_d  = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
  );

  // Data RAM model: synchronous write, asynchronous read, plus a bench preload path.
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (ram_we) mem[ram_a] <= ram_d;
  end
  assign ram_spo = mem[ram_a];

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    tick;
    ld_en = 1'b0;
  endtask

  // Raises h_req and runs until h_ack; h_req is left high on return.
  task automatic host_xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                           output int lat, output int nstall, output int stall_cyc);
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
    lat = 0; nstall = 0; stall_cyc = -1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick;
      if (c_stall) begin nstall++; stall_cyc = cyc; end
      if (h_ack) lat = i;
    end
    n_cmp++;
    if (lat == 0) begin n_fail++; $display("FAIL ack_timeout: no h_ack within 20 cycles (addr %h)", a); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h07; c_wdata = 32'h0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h09; h_wdata = 32'h0;
    @(negedge clk);
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL rst_h_ack: got %b want 0", h_ack); end
    n_cmp++; if (h_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_h_rdata: got %h want 0", h_rdata); end
    n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL rst_c_stall: got %b want 0", c_stall); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (ram_a !== 8'h07) begin n_fail++; $display("FAIL rst_ram_a: got %h want 07", ram_a); end
    load(8'h05, 32'h12345678);
    load(8'h03, 32'hCAFEF00D);
    load(8'h10, 32'h00000000);
    load(8'h20, 32'h55AA55AA);
    load(8'h50, 32'h00000000);
    load(8'h60, 32'h00000000);
    c_req = 1'b0; c_we = 1'b0; h_req = 1'b0;
    rst = 1'b0;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL post_rst_h_ack: got %b want 0", h_ack); end
  endtask

  task automatic test_uncontended_read;
    c_req = 1'b0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h05;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL unc_host_ack: got %b want 0", h_ack); end
    n_cmp++; if (ram_a !== 8'h05) begin n_fail++; $display("FAIL unc_host_ram_a: got %h want 05", ram_a); end
    n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL unc_stall: got %b want 0", c_stall); end
    tick;
    n_cmp++; if (h_ack !== 1'b1) begin n_fail++; $display("FAIL unc_ack: got %b want 1", h_ack); end
    n_cmp++; if (h_rdata !== 32'h12345678) begin n_fail++; $display("FAIL unc_rdata: got %h want 12345678", h_rdata); end
    h_req = 1'b0;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL unc_ack_pulse: got %b want 0", h_ack); end
    n_cmp++; if (h_rdata !== 32'h12345678) begin n_fail++; $display("FAIL unc_rdata_hold: got %h want 12345678", h_rdata); end
  endtask

  task automatic test_contended_write;
    int lat, ns, sc;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h40;
    host_xfer(1'b1, 8'h10, 32'hDEADBEEF, lat, ns, sc);
    n_cmp++; if (lat != MAX_WAIT + 2) begin n_fail++; $display("FAIL cont_latency: got %0d want %0d", lat, MAX_WAIT + 2); end
    n_cmp++; if (ns != 1) begin n_fail++; $display("FAIL cont_stall_cycles: got %0d want 1", ns); end
    n_cmp++; if (mem[8'h10] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_ram: got %h want deadbeef", mem[8'h10]); end
    n_cmp++; if (h_rdata !== 32'h0) begin n_fail++; $display("FAIL cont_prewrite_rdata: got %h want 0", h_rdata); end
    n_cmp++; if (ram_a !== 8'h40) begin n_fail++; $display("FAIL cont_cpu_owns_in_ack: got %h want 40", ram_a); end
    h_req = 1'b0; c_req = 1'b0;
    tick;
  endtask

  task automatic test_cpu_first;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h03;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h05;
    #1;
    n_cmp++; if (c_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cpu_first_rdata: got %h want cafef00d", c_rdata); end
    n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_first_stall: got %b want 0", c_stall); end
    tick;
    c_req = 1'b0;
    tick;
    n_cmp++; if (ram_a !== 8'h05) begin n_fail++; $display("FAIL cpu_first_grant: ram_a got %h want 05", ram_a); end
    tick;
    n_cmp++; if (h_ack !== 1'b1) begin n_fail++; $display("FAIL cpu_first_ack: got %b want 1", h_ack); end
    n_cmp++; if (h_rdata !== 32'h12345678) begin n_fail++; $display("FAIL cpu_first_hrdata: got %h want 12345678", h_rdata); end
    h_req = 1'b0;
    tick;
  endtask

  task automatic test_hold;
    int acks, lat, ns, sc;
    c_req = 1'b0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h03;
    tick;
    tick;
    n_cmp++; if (h_ack !== 1'b1) begin n_fail++; $display("FAIL hold_first_ack: got %b want 1", h_ack); end
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h07;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (h_ack) acks++;
      n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b want 0", i, c_stall); end
      n_cmp++; if (ram_a !== 8'h07) begin n_fail++; $display("FAIL hold_ram_a[%0d]: got %h want 07", i, ram_a); end
    end
    n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL hold_extra_acks: got %0d want 0", acks); end
    n_cmp++; if (h_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hold_rdata: got %h want cafef00d", h_rdata); end
    h_req = 1'b0; c_req = 1'b0;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL hold_release_ack: got %b want 0", h_ack); end
    host_xfer(1'b0, 8'h05, 32'h0, lat, ns, sc);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL hold_back_to_idle_latency: got %0d want 2", lat); end
    h_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_in_host;
    c_req = 1'b0; c_we = 1'b0; c_addr = 8'h07;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 32'h11111111;
    tick;
    c_req = 1'b1;
    #1;
    n_cmp++; if (c_stall !== 1'b1) begin n_fail++; $display("FAIL rih_stall_in_host: got %b want 1", c_stall); end
    n_cmp++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rih_host_we: got %b want 1", ram_we); end
    rst = 1'b1;
    #1;
    n_cmp++; if (c_stall !== 1'b0) begin n_fail++; $display("FAIL rih_stall_rst: got %b want 0", c_stall); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rih_ram_we_rst: got %b want 0", ram_we); end
    n_cmp++; if (ram_a !== 8'h07) begin n_fail++; $display("FAIL rih_ram_a_rst: got %h want 07", ram_a); end
    n_cmp++; if (h_rdata !== 32'h0) begin n_fail++; $display("FAIL rih_h_rdata_rst: got %h want 0", h_rdata); end
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL rih_ack_rst: got %b want 0", h_ack); end
    n_cmp++; if (mem[8'h20] !== 32'h55AA55AA) begin n_fail++; $display("FAIL rih_ram_unchanged: got %h want 55aa55aa", mem[8'h20]); end
    h_req = 1'b0; c_req = 1'b0; rst = 1'b0;
    tick;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL rih_no_late_ack: got %b want 0", h_ack); end
    n_cmp++; if (mem[8'h20] !== 32'h55AA55AA) begin n_fail++; $display("FAIL rih_ram_after: got %h want 55aa55aa", mem[8'h20]); end
  endtask

  task automatic test_withdraw;
    int lat, ns, sc;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h40;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h05;
    tick;
    tick;
    h_req = 1'b0;
    tick;
    n_cmp++; if (h_ack !== 1'b0) begin n_fail++; $display("FAIL wd_no_ack: got %b want 0", h_ack); end
    host_xfer(1'b0, 8'h05, 32'h0, lat, ns, sc);
    n_cmp++; if (lat != MAX_WAIT + 2) begin n_fail++; $display("FAIL wd_wait_cleared: latency got %0d want %0d", lat, MAX_WAIT + 2); end
    h_req = 1'b0; c_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int lat1, ns1, sc1, lat2, ns2, sc2;
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h60; c_wdata = 32'h0BADF00D;
    host_xfer(1'b1, 8'h50, 32'hA5A50001, lat1, ns1, sc1);
    h_req = 1'b0;
    tick;
    host_xfer(1'b0, 8'h50, 32'h0, lat2, ns2, sc2);
    n_cmp++; if (lat1 != MAX_WAIT + 2) begin n_fail++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, MAX_WAIT + 2); end
    n_cmp++; if (lat2 != MAX_WAIT + 2) begin n_fail++; $display("FAIL b2b_lat2: got %0d want %0d", lat2, MAX_WAIT + 2); end
    n_cmp++; if (ns1 != 1 || ns2 != 1) begin n_fail++; $display("FAIL b2b_stalls: got %0d,%0d want 1,1", ns1, ns2); end
    n_cmp++; if (sc2 - sc1 - 1 < MAX_WAIT) begin n_fail++; $display("FAIL b2b_gap: got %0d want >= %0d", sc2 - sc1 - 1, MAX_WAIT); end
    n_cmp++; if (h_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL b2b_order: got %h want a5a50001", h_rdata); end
    n_cmp++; if (mem[8'h60] !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_cpu_write: got %h want 0badf00d", mem[8'h60]); end
    h_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_uncontended_read;
    test_contended_write;
    test_cpu_first;
    test_hold;
    test_reset_in_host;
    test_withdraw;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
